// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-ported unified memory shared by instruction fetch and
// data access: grants the port, runs the req/ack handshake with timeout and steers byte lanes.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_write,
    input  logic              dm_byte,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    input  logic              halt,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_we,
    output logic [1:0]        m_be,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic [1:0]        state_dbg
);
    // Handshake: if_req/dm_req are held with their address/data stable until the matching
    // one-cycle valid pulse; a request still high in the IDLE cycle after that pulse is new.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              byte_q, byte_d;
    logic              lane_q, lane_d;
    logic              m_req_d, m_we_d, if_valid_d, dm_valid_d, bus_err_d;
    logic [1:0]        m_be_d;
    logic [ADDR_W-1:0] m_addr_d;
    logic [DATA_W-1:0] m_wdata_d, if_rdata_d, dm_rdata_d, rd_word;
    logic              if_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            last_q   <= OWN_IF;
            cnt_q    <= '0;
            byte_q   <= 1'b0;
            lane_q   <= 1'b0;
            m_req    <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_we     <= 1'b0;
            m_be     <= 2'b00;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
            bus_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            lane_q   <= lane_d;
            m_req    <= m_req_d;
            m_addr   <= m_addr_d;
            m_wdata  <= m_wdata_d;
            m_we     <= m_we_d;
            m_be     <= m_be_d;
            if_valid <= if_valid_d;
            dm_valid <= dm_valid_d;
            if_rdata <= if_rdata_d;
            dm_rdata <= dm_rdata_d;
            bus_err  <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        lane_d     = lane_q;
        m_req_d    = m_req;
        m_addr_d   = m_addr;
        m_wdata_d  = m_wdata;
        m_we_d     = m_we;
        m_be_d     = m_be;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        bus_err_d  = 1'b0;
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;
        if_ok      = if_req & ~halt;

        // Stores return zero; lbu picks the addressed lane and zero-extends it.
        rd_word = '0;
        if (!m_we) begin
            if (byte_q) rd_word = {8'h00, lane_q ? m_rdata[15:8] : m_rdata[7:0]};
            else        rd_word = m_rdata;
        end

        case (state_q)
            IDLE: begin
                // DM has priority except right after its own grant when a fetch is waiting.
                if (dm_req && !(last_q == OWN_DM && if_ok)) begin
                    owner_d = OWN_DM;
                    last_d  = OWN_DM;
                    cnt_d   = '0;
                    if (!dm_byte && dm_addr[0]) begin
                        state_d    = RESP;
                        dm_valid_d = 1'b1;
                        bus_err_d  = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        state_d   = BUSY;
                        m_req_d   = 1'b1;
                        m_addr_d  = dm_addr;
                        m_we_d    = dm_write;
                        byte_d    = dm_byte;
                        lane_d    = dm_addr[0];
                        m_be_d    = dm_byte ? (dm_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                        m_wdata_d = dm_byte ? {2{dm_wdata[7:0]}} : dm_wdata;
                    end
                end else if (if_ok) begin
                    owner_d  = OWN_IF;
                    last_d   = OWN_IF;
                    cnt_d    = '0;
                    state_d  = BUSY;
                    m_req_d  = 1'b1;
                    m_addr_d = if_addr;
                    m_we_d   = 1'b0;
                    m_be_d   = 2'b11;
                    byte_d   = 1'b0;
                    lane_d   = 1'b0;
                end
            end
            BUSY: begin
                if (m_ack || cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    m_be_d    = 2'b00;
                    bus_err_d = ~m_ack;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = m_ack ? rd_word : '0;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = m_ack ? rd_word : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder model, completion scoreboard and
// scenario tasks for fetch, byte lanes, alternation, timeout, misalignment, halt and reset.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int WAIT_MAX = 15;

    logic clk, reset, if_req, if_valid, dm_req, dm_write, dm_byte, dm_valid, halt;
    logic stall_if, stall_mem, bus_err, m_req, m_we, m_ack;
    logic [ADDR_W-1:0] if_addr, dm_addr, m_addr;
    logic [DATA_W-1:0] if_rdata, dm_rdata, dm_wdata, m_wdata, m_rdata;
    logic [1:0] m_be, state_dbg;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_write(dm_write),
        .dm_byte(dm_byte), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .halt(halt), .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_be(m_be),
        .m_rdata(m_rdata), .m_ack(m_ack), .state_dbg(state_dbg)
    );

    int errors = 0;
    int checks = 0;

    // scoreboard entry: {is_dm, bus_err, rdata}
    logic [17:0] exp_q[$];
    logic [15:0] grant_q[$];

    // memory model state
    bit          ack_en = 1'b1;
    int          ack_lat = 0;
    logic [15:0] mem_rdata = '0;
    int          mem_cnt = 0, cur_len = 0, last_len = 0, req_count = 0;
    logic [15:0] cap_addr, cap_wdata;
    logic [1:0]  cap_be;
    logic        cap_we;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory responder: acks ack_lat cycles after m_req rises
    initial begin
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (m_req) begin
                if (cur_len == 0) begin
                    req_count++;
                    grant_q.push_back(m_addr);
                end
                cur_len++;
                if (ack_en && mem_cnt == ack_lat) begin
                    m_ack = 1'b1;
                    m_rdata = mem_rdata;
                    cap_addr = m_addr; cap_wdata = m_wdata; cap_be = m_be; cap_we = m_we;
                    mem_cnt = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                if (cur_len != 0) last_len = cur_len;
                cur_len = 0;
                mem_cnt = 0;
            end
        end
    end

    // scoreboard: every valid pulse consumes one expected completion
    initial begin
        logic [17:0] obs, expv;
        forever begin
            @(negedge clk);
            if (if_valid || dm_valid) begin
                checks++;
                obs = {dm_valid, bus_err, dm_valid ? dm_rdata : if_rdata};
                if (if_valid && dm_valid) begin
                    errors++;
                    $display("FAIL sb_both_valid: if_valid and dm_valid together, required one");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h, required no completion", obs);
                end else begin
                    expv = exp_q.pop_front();
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL sb_completion: got %h, required %h", obs, expv);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_dm(input logic [15:0] a, input logic [15:0] wd, input logic wr,
                            input logic by);
        dm_req = 1'b1; dm_addr = a; dm_wdata = wd; dm_write = wr; dm_byte = by;
    endtask

    task automatic release_all();
        dm_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input bit dm, output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (dm ? dm_valid : if_valid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL wait_valid: no %s valid within 60 cycles", dm ? "dm" : "if");
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m_req, m_we, m_be, m_addr, m_wdata, if_valid, dm_valid, if_rdata, dm_rdata, bus_err}
            !== 71'b0) begin
            errors++;
            $display("FAIL reset_outputs: m_req=%b m_be=%b m_addr=%h, required all zero",
                     m_req, m_be, m_addr);
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, required 0", state_dbg);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int lat;
        mem_rdata = 16'hBEEF; ack_lat = 0;
        if_req = 1'b1; if_addr = 16'h0010;
        exp_q.push_back({1'b0, 1'b0, 16'hBEEF});
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_hi: got %b, required 1", stall_if);
        end
        wait_valid(1'b0, lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL fetch_latency: got %0d, required 2", lat); end
        checks++;
        if (stall_if !== 1'b0) begin
            errors++; $display("FAIL fetch_stall_lo: got %b, required 0", stall_if);
        end
        checks++;
        if ({cap_be, cap_we, cap_addr} !== {2'b11, 1'b0, 16'h0010}) begin
            errors++;
            $display("FAIL fetch_port: be=%b we=%b addr=%h, required 11 0 0010",
                     cap_be, cap_we, cap_addr);
        end
        release_all();
    endtask

    task automatic test_lbu();
        int lat;
        mem_rdata = 16'h12AB;
        drive_dm(16'h0021, 16'h0000, 1'b0, 1'b1);
        exp_q.push_back({1'b1, 1'b0, 16'h0012});
        #1;
        checks++;
        if (stall_mem !== 1'b1) begin
            errors++; $display("FAIL lbu_stall_mem: got %b, required 1", stall_mem);
        end
        wait_valid(1'b1, lat);
        checks++;
        if (cap_be !== 2'b10) begin errors++; $display("FAIL lbu_hi_be: got %b, required 10", cap_be); end
        release_all();
        drive_dm(16'h0020, 16'h0000, 1'b0, 1'b1);
        exp_q.push_back({1'b1, 1'b0, 16'h00AB});
        wait_valid(1'b1, lat);
        checks++;
        if (cap_be !== 2'b01) begin errors++; $display("FAIL lbu_lo_be: got %b, required 01", cap_be); end
        release_all();
    endtask

    task automatic test_sb();
        int lat;
        drive_dm(16'h0031, 16'h00CD, 1'b1, 1'b1);
        exp_q.push_back({1'b1, 1'b0, 16'h0000});
        wait_valid(1'b1, lat);
        checks++;
        if ({cap_we, cap_be, cap_wdata} !== {1'b1, 2'b10, 16'hCDCD}) begin
            errors++;
            $display("FAIL sb_port: we=%b be=%b wdata=%h, required 1 10 cdcd",
                     cap_we, cap_be, cap_wdata);
        end
        release_all();
        drive_dm(16'h0040, 16'h1234, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 16'h0000});
        wait_valid(1'b1, lat);
        checks++;
        if ({cap_we, cap_be, cap_wdata} !== {1'b1, 2'b11, 16'h1234}) begin
            errors++;
            $display("FAIL sw_port: we=%b be=%b wdata=%h, required 1 11 1234",
                     cap_we, cap_be, cap_wdata);
        end
        release_all();
    endtask

    task automatic test_random_loads();
        int lat;
        logic [15:0] a, rd, ev;
        logic by;
        logic [1:0] eb;
        for (int i = 0; i < 6; i++) begin
            by = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 16'hFFFF));
            if (!by) a[0] = 1'b0;
            rd = 16'($urandom_range(0, 16'hFFFF));
            mem_rdata = rd;
            ack_lat = $urandom_range(0, 3);
            ev = by ? {8'h00, a[0] ? rd[15:8] : rd[7:0]} : rd;
            eb = by ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            drive_dm(a, 16'h0, 1'b0, by);
            exp_q.push_back({1'b1, 1'b0, ev});
            wait_valid(1'b1, lat);
            checks++;
            if (lat != ack_lat + 2 || cap_be !== eb || cap_addr !== a) begin
                errors++;
                $display("FAIL rand_load%0d: lat=%0d be=%b addr=%h, required lat=%0d be=%b addr=%h",
                         i, lat, cap_be, cap_addr, ack_lat + 2, eb, a);
            end
            release_all();
        end
        ack_lat = 0;
    endtask

    task automatic test_alternate();
        int n;
        do_reset();
        grant_q.delete();
        mem_rdata = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, 1'b0, 16'h5A5A});
            exp_q.push_back({1'b0, 1'b0, 16'h5A5A});
        end
        if_req = 1'b1; if_addr = 16'h0100;
        drive_dm(16'h0200, 16'h0, 1'b0, 1'b0);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (if_valid || dm_valid) n++;
            if (n == 8) break;
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL alt_count: got %0d completions, required 8", n); end
        release_all();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (grant_q.size() <= i || grant_q[i] !== ((i % 2 == 0) ? 16'h0200 : 16'h0100)) begin
                errors++;
                $display("FAIL alt_order%0d: got %h, required %h", i,
                         (grant_q.size() > i) ? grant_q[i] : 16'hxxxx,
                         (i % 2 == 0) ? 16'h0200 : 16'h0100);
            end
        end
    endtask

    task automatic test_timeout();
        int lat;
        ack_en = 1'b0;
        drive_dm(16'h0050, 16'h0, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 16'h0000});
        wait_valid(1'b1, lat);
        checks++;
        if (lat != WAIT_MAX + 1) begin
            errors++; $display("FAIL timeout_latency: got %0d, required %0d", lat, WAIT_MAX + 1);
        end
        release_all();
        checks++;
        if (last_len != WAIT_MAX) begin
            errors++; $display("FAIL timeout_req_len: got %0d, required %0d", last_len, WAIT_MAX);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_misaligned();
        int lat, rc;
        rc = req_count;
        drive_dm(16'h0003, 16'h1111, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 16'h0000});
        wait_valid(1'b1, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL misalign_latency: got %0d, required 1", lat); end
        release_all();
        checks++;
        if (req_count != rc) begin
            errors++; $display("FAIL misalign_no_mreq: got %0d requests, required %0d", req_count, rc);
        end
    endtask

    task automatic test_halt();
        int lat, rc;
        mem_rdata = 16'h7E57; ack_lat = 3;
        if_req = 1'b1; if_addr = 16'h0110;
        exp_q.push_back({1'b0, 1'b0, 16'h7E57});
        repeat (2) @(negedge clk);
        halt = 1'b1;
        wait_valid(1'b0, lat);
        release_all();
        ack_lat = 0;
        rc = req_count;
        if_req = 1'b1; if_addr = 16'h0120;
        repeat (8) @(negedge clk);
        checks++;
        if (req_count != rc || stall_if !== 1'b1) begin
            errors++;
            $display("FAIL halt_block: requests=%0d stall_if=%b, required %0d 1", req_count, stall_if, rc);
        end
        drive_dm(16'h0200, 16'h0, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 16'h7E57});
        wait_valid(1'b1, lat);
        checks++;
        if (cap_addr !== 16'h0200) begin
            errors++; $display("FAIL halt_dm_served: addr=%h, required 0200", cap_addr);
        end
        dm_req = 1'b0; halt = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 16'h7E57});
        wait_valid(1'b0, lat);
        checks++;
        if (cap_addr !== 16'h0120) begin
            errors++; $display("FAIL halt_release: addr=%h, required 0120", cap_addr);
        end
        release_all();
    endtask

    task automatic test_reset_mid_busy();
        ack_en = 1'b0;
        drive_dm(16'h0060, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (m_req !== 1'b1) begin errors++; $display("FAIL midreset_busy: m_req=%b, required 1", m_req); end
        reset = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_req, m_we, m_be, m_addr, m_wdata, if_valid, dm_valid, if_rdata, dm_rdata, bus_err,
             state_dbg} !== 73'b0) begin
            errors++;
            $display("FAIL midreset_outputs: m_req=%b m_addr=%h state=%0d, required all zero",
                     m_req, m_addr, state_dbg);
        end
        @(negedge clk);
        reset = 1'b0;
        ack_en = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_addr = '0; dm_wdata = '0; dm_write = 1'b0; dm_byte = 1'b0;
        test_reset();
        test_fetch();
        test_lbu();
        test_sb();
        test_random_loads();
        test_alternate();
        test_timeout();
        test_misaligned();
        test_halt();
        test_reset_mid_busy();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d completions missing, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
